// File: rtl/mod_counter_if.sv
// Bundles the mod_counter control inputs and count outputs into one port.
// The master side drives the controls; the counter is the slave.
interface mod_counter_if #(
  parameter int N = 8
);
  logic         en;
  logic         up;
  logic [N-1:0] lim;
  logic         load;
  logic [N-1:0] ld_val;
  logic         sat;
  logic [N-1:0] q;
  logic         tc;
  logic         wrap;

  modport master (
    output en, up, lim, load, ld_val, sat,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up, lim, load, ld_val, sat,
    output q, tc, wrap
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter over 0..lim with load, terminal count and wrap pulse.
// Define MOD_COUNTER_SAT_EN to let the sat input choose saturation instead of wrapping.
module mod_counter #(
  parameter int N    = 8,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mod_counter_if.slave bus
);

  localparam logic [N-1:0] INIT_VAL = N'(INIT);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         sat_mode;

`ifdef MOD_COUNTER_SAT_EN
  assign sat_mode = bus.sat;
`else
  logic unused_sat;
  assign unused_sat = bus.sat;
  assign sat_mode   = 1'b0;
`endif

  // Next state: load beats count; q above a lowered lim recovers in one step either way.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = (bus.ld_val <= bus.lim) ? bus.ld_val : bus.lim;
    end else if (bus.en) begin
      if (bus.up) begin
        if (q_q < bus.lim) begin
          q_d = q_q + 1'b1;
        end else begin
          wrap_d = 1'b1;
          q_d    = sat_mode ? bus.lim : '0;
        end
      end else begin
        if (q_q == '0) begin
          wrap_d = 1'b1;
          q_d    = sat_mode ? '0 : bus.lim;
        end else if (q_q > bus.lim) begin
          q_d = bus.lim;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= INIT_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // tc is deliberately unqualified by en so stages cascade as en & tc.
  assign bus.tc   = bus.up ? (q_q >= bus.lim) : (q_q == '0);
  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;

endmodule
